// File: rtl/ula_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter_if
// Brief    : Requester-side handshake and response bus of the shared-ULA
//            round-robin arbiter (one slice per requester).
// Revision : 1.0 - initial release
// ============================================================================
interface ula_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;
  logic              rsp_invalid;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_invalid
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_invalid
  );
endinterface
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter
// Brief    : Round-robin arbiter sharing one combinational ULA among NREQ
//            requesters; fixed 2-cycle latency. Stats counters are built only
//            when ULA_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ula_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               hold,
  ula_arbiter_if.slave            bus,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [2:0]              alu_ctrl,
  input  wire logic [W-1:0]       alu_result,
  input  wire logic               alu_zero,
  output logic [NREQ*32-1:0]      grant_cnt,
  output logic [31:0]             invalid_cnt
);

  localparam int              c_IDX_W = $clog2(NREQ);
  localparam logic [NREQ-1:0] c_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  logic [c_IDX_W-1:0] r_last_grant;
  logic               r_ex_valid;
  logic [c_IDX_W-1:0] r_ex_owner;
  logic               r_ex_invalid;
  logic [W-1:0]       r_alu_a;
  logic [W-1:0]       r_alu_b;
  logic [2:0]         r_alu_ctrl;
  logic [NREQ-1:0]    r_rsp_valid;
  logic [W-1:0]       r_rsp_result;
  logic               r_rsp_zero;
  logic               r_rsp_invalid;

  logic               w_found;
  logic               w_accept;
  logic [c_IDX_W-1:0] w_cand;
  logic [c_IDX_W-1:0] w_grant_idx;
  logic [NREQ-1:0]    w_grant;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;
  logic [2:0]         w_sel_op;
  logic               w_sel_invalid;

  // Search starts one past the last accepted requester and wraps at NREQ.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = c_IDX_W'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_accept      = w_found & ~hold;
    w_grant       = w_accept ? (c_ONE << w_grant_idx) : '0;
    w_sel_a       = bus.req_a[w_grant_idx*W +: W];
    w_sel_b       = bus.req_b[w_grant_idx*W +: W];
    w_sel_op      = bus.req_op[w_grant_idx*3 +: 3];
    w_sel_invalid = !(w_sel_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= c_IDX_W'(NREQ - 1);
      r_ex_valid    <= 1'b0;
      r_ex_owner    <= '0;
      r_ex_invalid  <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctrl    <= '0;
      r_rsp_valid   <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_invalid <= 1'b0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_ex_owner   <= w_grant_idx;
        r_ex_invalid <= w_sel_invalid;
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_ctrl   <= w_sel_op;
      end
      // Response side has no backpressure: EX always drains into RSP.
      r_rsp_valid <= r_ex_valid ? (c_ONE << r_ex_owner) : '0;
      if (r_ex_valid) begin
        r_rsp_result  <= alu_result;
        r_rsp_zero    <= alu_zero;
        r_rsp_invalid <= r_ex_invalid;
      end
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_zero    = r_rsp_zero;
  assign bus.rsp_invalid = r_rsp_invalid;
  assign alu_a           = r_alu_a;
  assign alu_b           = r_alu_b;
  assign alu_ctrl        = r_alu_ctrl;

`ifdef ULA_ARB_STATS_EN
  logic [31:0] r_invalid_cnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_grant[gi]) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign grant_cnt[gi*32 +: 32] = r_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_invalid_cnt <= '0;
    end else if (w_accept && w_sel_invalid) begin
      r_invalid_cnt <= r_invalid_cnt + 32'd1;
    end
  end

  assign invalid_cnt = r_invalid_cnt;
`else
  assign grant_cnt   = '0;
  assign invalid_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_arbiter
// Brief    : Self-checking bench for ula_arbiter: vector table plus scoreboard
//            of expected responses, and hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
`ifdef ULA_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [W-1:0]      alu_a, alu_b, alu_result;
  logic [2:0]        alu_ctrl;
  logic              alu_zero;
  logic [NREQ*32-1:0] grant_cnt;
  logic [31:0]       invalid_cnt;

  ula_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  ula_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .bus         (bus.slave),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .grant_cnt   (grant_cnt),
    .invalid_cnt (invalid_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ula_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Shared combinational ULA seen by the arbiter.
  always_comb begin
    alu_result = ula_ref(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        zero;
    logic        inv;
    int          due;
  } exp_t;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        inv;
  } vec_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_grant[NREQ];
  int   exp_inv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int owner, input logic [31:0] res, input logic zero,
                          input logic inv);
    exp_t e;
    e.owner = owner; e.res = res; e.zero = zero; e.inv = inv; e.due = cyc + 2;
    sbq.push_back(e);
    exp_grant[owner]++;
    if (inv) exp_inv++;
  endtask

  // Response monitor: every pulse must match the oldest expected entry.
  initial begin : p_monitor
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e  = sbq.pop_front();
          oh = '0; oh[e.owner] = 1'b1;
          check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
          check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
          check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
          check("rsp_invalid", 64'(bus.rsp_invalid), 64'(e.inv));
          check("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e  = sbq.pop_front();
        oh = '0; oh[e.owner] = 1'b1;
        check("rsp_missing", 64'(bus.rsp_valid), 64'(oh));
      end
    end
  end

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_op[r*3 +: 3]  = op;
  endtask

  task automatic issue(input vec_t v);
    bit         got;
    logic [3:0] oh;
    got = 1'b0;
    oh  = '0; oh[v.r] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = oh;
    set_req(v.r, v.a, v.b, v.op);
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready[v.r]) begin
        got = 1'b1;
        check("grant_onehot", 64'(bus.req_ready), 64'(oh));
        push_exp(v.r, v.res, v.zero, v.inv);
      end
    end
    if (!got) check("grant_timeout", 64'(bus.req_ready), 64'(oh));
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    if (got) begin
      check("ex_alu_a", 64'(alu_a), 64'(v.a));
      check("ex_alu_b", 64'(alu_b), 64'(v.b));
      check("ex_alu_ctrl", 64'(alu_ctrl), 64'(v.op));
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 10 && sbq.size() != 0; t++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_grant[i] = 0;
    exp_inv = 0;
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < NREQ; i++)
      check({tag, "_grant_cnt"}, 64'(grant_cnt[i*32 +: 32]), STATS ? 64'(exp_grant[i]) : 64'd0);
    check({tag, "_invalid_cnt"}, 64'(invalid_cnt), STATS ? 64'(exp_inv) : 64'd0);
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    vec_t vecs[10];
    vec_t v;
    vecs[0] = '{0, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{1, 32'hF0F0,     32'h0FF0,     3'b000, 32'h00F0,     1'b0, 1'b0};
    vecs[2] = '{2, 32'hF000,     32'h000F,     3'b001, 32'hF00F,     1'b0, 1'b0};
    vecs[3] = '{3, 32'd9,        32'd9,        3'b110, 32'd0,        1'b1, 1'b0};
    vecs[4] = '{0, 32'hF0,       32'h0F,       3'b011, 32'd0,        1'b1, 1'b1};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0, 1'b0};
    vecs[6] = '{2, 32'd1,        32'hFFFFFFFF, 3'b111, 32'd0,        1'b1, 1'b0};
    vecs[7] = '{3, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1, 1'b0};
    vecs[8] = '{0, 32'd3,        32'd5,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[9] = '{1, 32'h12345678, 32'd0,        3'b101, 32'd0,        1'b1, 1'b1};

    reset = 1'b1;
    hold  = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    for (int i = 0; i < NREQ; i++) exp_grant[i] = 0;

    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check_stats("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);
    drain();
    check_stats("table");

    // Rotation: all requesters pending for 8 cycles after reset.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 + i), 32'(i), 3'b010);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] oh;
      oh = '0; oh[k % NREQ] = 1'b1;
      @(negedge clk);
      check("rr_grant", 64'(bus.req_ready), 64'(oh));
      push_exp(k % NREQ, 32'(100 + 2 * (k % NREQ)), 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Hold: req1 accepted just before hold; req2 blocked for 3 cycles.
    @(posedge clk); #1;
    set_req(1, 32'd40, 32'd2, 3'b010);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("hold_pre_grant", 64'(bus.req_ready), 64'b0010);
    push_exp(1, 32'd42, 1'b0, 1'b0);
    @(posedge clk); #1;
    hold = 1'b1;
    set_req(2, 32'd7, 32'd3, 3'b001);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.req_ready), 64'd0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    check("hold_release_grant", 64'(bus.req_ready), 64'b0100);
    push_exp(2, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Reset in the cycle after a grant: the in-flight op must vanish.
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd2, 3'b010);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("midrst_grant", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_alu_a", 64'(alu_a), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_grant[i] = 0;
    exp_inv = 0;
    @(negedge clk);
    check("postrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("postrst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("postrst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
    check("postrst_rsp_invalid", 64'(bus.rsp_invalid), 64'd0);
    check("postrst_alu_a", 64'(alu_a), 64'd0);
    check("postrst_alu_b", 64'(alu_b), 64'd0);
    check("postrst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check_stats("postrst");
    @(posedge clk); #1;
    set_req(0, 32'd20, 32'd5, 3'b110);
    set_req(3, 32'd1, 32'd1, 3'b010);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("postrst_contest", 64'(bus.req_ready), 64'b0001);
    push_exp(0, 32'd15, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Five grants to requester 1 for the counters.
    for (int k = 0; k < 5; k++) begin
      v = '{1, 32'(k), 32'd1, 3'b010, 32'(k + 1), 1'b0, 1'b0};
      issue(v);
    end
    drain();
    check_stats("final");
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ula_arbiter.md
# ula_arbiter

Round-robin arbiter that shares one combinational `ula` instance among `NREQ` requesters (e.g. EX-stage ALU, branch-compare unit, address-generation unit) in the MIPS pipeline. It accepts one request per cycle through a valid/ready handshake and drives registered operands into the shared ULA. It captures the ULA result and returns it to the winning requester with a fixed 2-cycle latency. A `hold` input from the hazard unit blocks new grants without disturbing in-flight operations.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `W`, 32, datapath width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `hold`  in  1  1 = no new grant this cycle
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`
- `req_a`, `req_b`  in  NREQ*W  operands; slice i = bits `[i*W +: W]`
- `req_op`  in  NREQ*3  ULAcontrol code; slice i = bits `[i*3 +: 3]`
- `alu_a`, `alu_b`  out  W  to the shared ULA `a`/`b` inputs
- `alu_ctrl`  out  3  to the ULA `ULAcontrol` input
- `alu_result`  in  W  from the ULA `result` output
- `alu_zero`  in  1  from the ULA `zero` output
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse to the owner of the returned result
- `rsp_result`  out  W  returned result
- `rsp_zero`  out  1  returned zero flag
- `rsp_invalid`  out  1  returned op code was not a valid code
- `grant_cnt`  out  NREQ*32  per-requester accepted-request counters (stats build only)
- `invalid_cnt`  out  32  count of accepted invalid op codes (stats build only)

## Operation
- **Valid op codes:** 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Any other code is still issued, and its response carries `rsp_invalid = 1`.
- **Arbitration:** combinational round-robin.
  - Search order starts at `(last_grant + 1) mod NREQ`; the first set `req_valid` bit wins.
  - `req_ready` is one-hot on the winner and all-zero when `hold = 1` or no request is pending.
  - `req_ready` never asserts without the matching `req_valid`.
  - `last_grant` updates only on an accepted request.
- **Pipeline stages:** each carries a valid bit and an owner index.
  - **ISSUE (cycle T, acceptance):** operands, op, owner and invalid flag are registered into the EX stage.
  - **EX (cycle T+1):** EX registers drive `alu_a`/`alu_b`/`alu_ctrl`. At the T+1→T+2 edge, `alu_result`, `alu_zero` and the invalid flag are registered into the RSP stage.
  - **RSP (cycle T+2):** `rsp_valid[owner] = 1` together with the registered result, zero and invalid outputs.
- **Idle stages:** when EX is idle, `alu_a`/`alu_b`/`alu_ctrl` hold their last values. When RSP is idle, `rsp_valid = 0` and the `rsp_*` data outputs hold their last values.
- **Backpressure:** there is none on the response side. Requesters must accept `rsp_valid` whenever it pulses.
- **Throughput:** 1 op/cycle; back-to-back grants to the same requester are allowed when it is the only requester.

## Timing
- **Latency:** 2 cycles from acceptance edge T to `rsp_valid` asserted in cycle T+2.
- **`hold`:** combinational effect on `req_ready` in the same cycle. Operations already in EX/RSP complete normally.
- **Reset values:** `req_ready`, `rsp_valid`, `rsp_result`, `rsp_zero`, `rsp_invalid`, `alu_a`, `alu_b`, `alu_ctrl` and all counters are 0. `last_grant = NREQ-1`, so requester 0 has first priority.
- **Reset mid-operation:** in-flight EX/RSP operations are discarded and no response is produced for them.
- **Round-robin wrap:** after granting `NREQ-1`, the search restarts at 0.
- **Counters:** 32-bit, wrap from 0xFFFFFFFF to 0. Each increments on the acceptance edge.

## Configuration
- **`ULA_ARB_STATS_EN` defined:**
  - `grant_cnt[i]` increments on each accepted request from requester i.
  - `invalid_cnt` increments on each accepted request whose op is not in the valid set.
- **`ULA_ARB_STATS_EN` undefined:** the counter registers are not built, and `grant_cnt` and `invalid_cnt` are tied to 0. All other behaviour is identical.

## Test plan
- **Single ADD:** requester 0 issues ADD a=5, b=7 → `req_ready = 0001` in cycle T; `alu_ctrl = 010` in T+1; `rsp_valid = 0001`, `rsp_result = 12`, `rsp_zero = 0` in T+2.
- **Round-robin rotation:** all 4 requesters hold valid for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3. Each response returns to its owner exactly 2 cycles after its grant.
- **SUB to zero, then invalid op:** SUB a=9, b=9 → `rsp_result = 0`, `rsp_zero = 1`. Then op=011 with a=0xF0, b=0x0F → `rsp_invalid = 1`, and with stats enabled `invalid_cnt = 1`.
- **Hold:** requester 2 issues while `hold = 1` for 3 cycles → `req_ready = 0` for those cycles. An operation accepted just before `hold` rises still responds at T+2. Requester 2 is granted in the first cycle after `hold` falls.
- **Reset mid-flight:** assert `reset` in the cycle after a grant → no `rsp_valid` follows. After release, all outputs are 0 and requester 0 wins the first contested arbitration against requester 3.
- **Stats build:** with `ULA_ARB_STATS_EN`, 5 grants to requester 1 → `grant_cnt` slice 1 = 5. Without the macro, `grant_cnt` and `invalid_cnt` stay 0 throughout.
